// File: rtl/seq_link_pkg.sv
// Shared definitions for the 10010 sync-pattern serial link
// (transmitter and Mealy detector).
package seq_link_pkg;

  localparam logic [4:0] SYNC_PAT = 5'b10010;
  localparam int         SYNC_LEN = 5;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE    = 2'd0;
  localparam tx_state_t SYNC    = 2'd1;
  localparam tx_state_t PAYLOAD = 2'd2;
  localparam tx_state_t GAP     = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period enable: bit_end is high on the last clk cycle of each serial bit.
// clr restarts the period so a new frame's first bit gets its full CLK_DIV cycles.
module bit_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rest,
  input  logic clr,
  output logic bit_end
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rest || clr || bit_end) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/seq_tx_10010.sv
// Serial frame transmitter: sync 10010, payload MSB first, GAP_BITS zeros,
// each bit held CLK_DIV cycles. w is a flop, so start/data never reach the line combinationally.
module seq_tx_10010
  import seq_link_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              w,
  output logic              frame_active,
  output logic              done
);

  // One down-counter serves as sync index, payload bit count and gap count.
  localparam int IDX_MAX = max_int(max_int(SYNC_LEN, DATA_W), GAP_BITS);
  localparam int IDX_W   = $clog2(IDX_MAX);

  tx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              done_nxt, w_nxt;
  logic              accept, bit_end;

  assign ready        = (state == IDLE);
  assign frame_active = (state != IDLE);
  assign accept       = start && ready;

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rest    (rest),
    .clr     (accept),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt = data;
          state_nxt = SYNC;
          idx_nxt   = IDX_W'(SYNC_LEN - 1);
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (idx == '0) begin
            state_nxt = PAYLOAD;
            idx_nxt   = IDX_W'(DATA_W - 1);
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
      PAYLOAD: begin
        if (bit_end) begin
          shreg_nxt = shreg << 1;
          if (idx == '0) begin
            if (GAP_BITS > 0) begin
              state_nxt = GAP;
              idx_nxt   = IDX_W'(GAP_BITS - 1);
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
      default: begin
        if (bit_end) begin
          if (idx == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Line value is derived from the next state so w changes exactly on the bit boundary.
  always_comb begin
    w_nxt = 1'b0;
    case (state_nxt)
      SYNC:    w_nxt = SYNC_PAT[idx_nxt[2:0]];
      PAYLOAD: w_nxt = shreg_nxt[DATA_W-1];
      default: w_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
      w     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      w     <= w_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_tx_10010.sv
// Bench for seq_tx_10010: frame-level reference model, vector table, corner sequences.
module tb_seq_tx_10010;

  localparam int CD = 4;
  localparam int FL = 15;
  localparam int L  = FL * CD;

  logic       clk = 1'b0;
  logic       rest, start;
  logic [7:0] data;
  logic       ready, w, frame_active, done;
  logic       b_start;
  logic [7:0] b_data;
  logic       b_ready, b_w, b_active, b_done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_tx_10010 #(.DATA_W(8), .CLK_DIV(4), .GAP_BITS(2)) dut (
    .clk(clk), .rest(rest), .start(start), .data(data),
    .ready(ready), .w(w), .frame_active(frame_active), .done(done)
  );

  seq_tx_10010 #(.DATA_W(8), .CLK_DIV(1), .GAP_BITS(0)) dut_b (
    .clk(clk), .rest(rest), .start(b_start), .data(b_data),
    .ready(b_ready), .w(b_w), .frame_active(b_active), .done(b_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a frame is the bit string {sync, payload, gap}; m_pos counts cycles into it.
  int            m_pos   = -1;
  logic [FL-1:0] m_frame = '0;
  logic          m_done  = 1'b0;
  logic          ew;

  always @(posedge clk) begin
    if (rest) begin
      m_pos  <= -1;
      m_done <= 1'b0;
    end else if (m_pos < 0 && start) begin
      m_frame <= {5'b10010, data, 2'b00};
      m_pos   <= 0;
      m_done  <= 1'b0;
    end else if (m_pos == L - 1) begin
      m_pos  <= -1;
      m_done <= 1'b1;
    end else begin
      if (m_pos >= 0) m_pos <= m_pos + 1;
      m_done <= 1'b0;
    end
  end

  always_comb ew = (m_pos < 0) ? 1'b0 : m_frame[FL - 1 - m_pos / CD];

  always @(negedge clk)
    if (chk_en)
      chk("model", {28'd0, w, ready, frame_active, done},
          {28'd0, ew, (m_pos < 0), (m_pos >= 0), m_done});

  // Pulse start at a negedge, sample mid-bit, optionally poke start mid-frame.
  task automatic send_frame(input logic [7:0] d, input int inject, output logic [FL-1:0] bits);
    bits  = '0;
    start = 1'b1;
    data  = d;
    @(negedge clk);
    for (int c = 1; c <= L; c++) begin
      if (c == inject) begin start = 1'b1; data = ~d; end
      else begin start = 1'b0; data = d; end
      if ((c - 1) % CD == 1) bits[FL - 1 - (c - 1) / CD] = w;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_ready_at_61", {30'd0, done, ready}, 32'd3);
  endtask

  // 10010 Mealy detector over the recovered bit stream (line idles at 0 beforehand).
  function automatic int det_count(input logic [FL-1:0] bits, output int pos);
    logic [4:0] hist = 5'b0;
    int n = 0;
    pos = -1;
    for (int i = 0; i < FL; i++) begin
      hist = {hist[3:0], bits[FL - 1 - i]};
      if (hist == 5'b10010) begin n++; pos = i; end
    end
    return n;
  endfunction

  typedef struct {
    logic [7:0]    d;
    logic [FL-1:0] bits;
    int            inject;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [FL-1:0] got;
    logic [12:0]   bexp;
    logic [7:0]    bd[3];
    int            nd, dpos, dcnt;

    tbl[0] = '{8'hA5, 15'b100101010010100, 0};
    tbl[1] = '{8'h00, 15'b100100000000000, 0};
    tbl[2] = '{8'hFF, 15'b100101111111100, 0};
    tbl[3] = '{8'h3C, 15'b100100011110000, 22};

    rest = 1'b1; start = 1'b1; data = 8'hA5; b_start = 1'b0; b_data = 8'h00;
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_outputs", {28'd0, w, ready, frame_active, done}, 32'h4);
      if (i < 2) @(negedge clk);
    end
    rest = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {31'd0, frame_active}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].d, tbl[i].inject, got);
      chk($sformatf("vec%0d_bits", i), {17'd0, got}, {17'd0, tbl[i].bits});
      if (i == 1) begin
        dcnt = det_count(got, dpos);
        chk("det_z_count", dcnt, 1);
        chk("det_z_pos", dpos, 4);
      end
    end
    repeat (2) @(negedge clk);

    // start held high, payload swapped in each done cycle
    start = 1'b1; data = 8'hFF; nd = 0;
    for (int c = 1; c <= 3 * (L + 1); c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        data = (data == 8'hFF) ? 8'h0F : 8'hFF;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 3);
    repeat (2) @(negedge clk);

    // reset during payload bit 3 (line bit 8, cycles 33..36)
    start = 1'b1; data = 8'h96;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
    chk("pre_reset_w", {31'd0, w}, 32'd1);
    rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    chk("post_reset", {28'd0, w, ready, frame_active, done}, 32'h4);
    nd = 0;
    for (int c = 0; c < 70; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("no_done_after_reset", nd, 0);
    send_frame(8'h5A, 0, got);
    chk("frame_after_reset", {17'd0, got}, {17'd0, 15'b100100101101000});
    repeat (2) @(negedge clk);

    // CLK_DIV=1, GAP_BITS=0 instance
    bd[0] = 8'hC3; bd[1] = 8'h12; bd[2] = 8'($urandom);
    for (int f = 0; f < 3; f++) begin
      b_start = 1'b1; b_data = bd[f];
      @(negedge clk);
      b_start = 1'b0;
      bexp = {5'b10010, bd[f]};
      for (int i = 0; i < 13; i++) begin
        chk("b_line", {29'd0, b_w, b_ready, b_active}, {29'd0, bexp[12 - i], 2'b01});
        @(negedge clk);
      end
      chk("b_done_at_14", {30'd0, b_done, b_ready}, 32'd3);
      @(negedge clk);
      chk("b_done_single", {31'd0, b_done}, 32'd0);
    end

    for (int c = 0; c < 1500; c++) begin
      rest  = ($urandom % 150) == 0;
      start = ($urandom % 3) == 0;
      data  = 8'($urandom);
      @(negedge clk);
    end
    rest = 1'b0; start = 1'b0;
    repeat (70) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
